// File: rtl/fadd_share_pkg.sv
// Shared constants and helpers for the shared FP-adder front end.
package fadd_share_pkg;

    localparam int FADD_LAT = 2;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RDN = 2'd2;
    localparam logic [1:0] RM_RUP = 2'd3;

    // Wide enough for any supported requester count (up to 8).
    typedef logic [2:0] id_t;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fadd_share_ctrl_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, else lowest set request.
module rr_arb
    import fadd_share_pkg::*;
#(
    parameter int  NREQ = 2,
    localparam int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (en && !found && req[i] && (i >= int'(ptr))) begin
                found      = 1'b1;
                gnt[i]     = 1'b1;
                gnt_idx    = IDW'(i);
            end
        end
        // Wrap-around pass picks the lowest request below ptr.
        for (int i = 0; i < NREQ; i++) begin
            if (en && !found && req[i]) begin
                found      = 1'b1;
                gnt[i]     = 1'b1;
                gnt_idx    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/fadd_share_ctrl.sv
// Shares one pipelined FP adder between NREQ requesters with round-robin issue and a tagged result port.
// Optional perf counters (perf_issue, perf_stall) exist only when FADD_SHARE_PERF_EN is defined.
module fadd_share_ctrl
    import fadd_share_pkg::*;
#(
    parameter int  NREQ = 2,
    parameter int  LAT  = FADD_LAT,
    parameter int  CW   = 32,
    localparam int IDW  = idw(NREQ)
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [2*NREQ-1:0]    req_rm,
    output logic [31:0]          fa_a,
    output logic [31:0]          fa_b,
    output logic                 fa_sub,
    output logic [1:0]           fa_rm,
    output logic                 fa_e,
    input  logic [31:0]          fa_s,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_s,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
`ifdef FADD_SHARE_PERF_EN
    ,
    output logic [CW-1:0]        perf_issue,
    output logic [CW-1:0]        perf_stall
`endif
);

    // Both ports use valid/ready: a transfer happens on a cycle where both are high;
    // the source holds its payload stable until then.

    logic [LAT-1:0]  tag_v;
    logic [IDW-1:0]  tag_id [LAT];
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            arb_en;
    logic            any_gnt;

    // Outputs are forced idle while reset is asserted, so the adder keeps running (fa_e=1).
    assign rsp_valid = tag_v[LAT-1] & clrn;
    assign rsp_id    = tag_id[LAT-1];
    assign rsp_s     = fa_s;
    assign busy      = (|tag_v) & clrn;
    assign fa_e      = ~rsp_valid | rsp_ready;
    assign arb_en    = fa_e & clrn;
    assign any_gnt   = |gnt;
    assign req_ready = gnt;
    assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A cycle with no grant feeds a zero bubble into the adder.
    always_comb begin
        fa_a   = '0;
        fa_b   = '0;
        fa_sub = 1'b0;
        fa_rm  = RM_RNE;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                fa_a   = req_a[32*i +: 32];
                fa_b   = req_b[32*i +: 32];
                fa_sub = req_sub[i];
                fa_rm  = req_rm[2*i +: 2];
            end
        end
    end

    // Tag pipe advances in lockstep with the adder's pipeline registers.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            tag_v  <= '0;
            rr_ptr <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else if (fa_e) begin
            tag_v[0]  <= any_gnt;
            tag_id[0] <= gnt_idx;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            if (any_gnt) begin
                rr_ptr <= ptr_next;
            end
        end
    end

`ifdef FADD_SHARE_PERF_EN
    always_ff @(posedge clk) begin
        if (!clrn) begin
            perf_issue <= '0;
            perf_stall <= '0;
        end else begin
            if (any_gnt && !(&perf_issue)) begin
                perf_issue <= perf_issue + CW'(1);
            end
            if (!fa_e && (|req_valid) && !(&perf_stall)) begin
                perf_stall <= perf_stall + CW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Bench for fadd_share_ctrl with a behavioural 2-register FP adder; FADD_SHARE_PERF_EN adds perf checks.
module tb_fadd_share_ctrl;
    import fadd_share_pkg::*;

    localparam int NREQ = 3;
    localparam int LAT  = FADD_LAT;
    localparam int CW   = 32;
    localparam int IDW  = idw(NREQ);

    localparam logic [31:0] F_ONE   = 32'h3F80_0000;
    localparam logic [31:0] F_TWO   = 32'h4000_0000;
    localparam logic [31:0] F_THREE = 32'h4040_0000;
    localparam logic [31:0] F_FOUR  = 32'h4080_0000;

    logic                clk;
    logic                clrn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_sub;
    logic [2*NREQ-1:0]   req_rm;
    logic [31:0]         fa_a;
    logic [31:0]         fa_b;
    logic                fa_sub;
    logic [1:0]          fa_rm;
    logic                fa_e;
    logic [31:0]         fa_s;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_s;
    logic [IDW-1:0]      rsp_id;
    logic                busy;
`ifdef FADD_SHARE_PERF_EN
    logic [CW-1:0]       perf_issue;
    logic [CW-1:0]       perf_stall;
`endif

    fadd_share_ctrl #(.NREQ(NREQ), .LAT(LAT), .CW(CW)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_rm    (req_rm),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_sub    (fa_sub),
        .fa_rm     (fa_rm),
        .fa_e      (fa_e),
        .fa_s      (fa_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef FADD_SHARE_PERF_EN
        ,
        .perf_issue(perf_issue),
        .perf_stall(perf_stall)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- float helpers (normal numbers and zero) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real r;
        r = sub ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b));
        return r2f(r);
    endfunction

    // ---------------- adder stand-in: align->cal and cal->norm registers ----------------
    logic [31:0] ad_r0, ad_r1;
    always @(posedge clk) begin
        if (!clrn) begin
            ad_r0 <= '0;
            ad_r1 <= '0;
        end else if (fa_e) begin
            ad_r0 <= fadd(fa_a, fa_b, fa_sub);
            ad_r1 <= ad_r0;
        end
    end
    assign fa_s = ad_r1;

    // ---------------- bookkeeping ----------------
    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [1:0]  rm;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] s;
        int          issued;
    } fly_t;

    typedef struct {
        int          id;
        logic [31:0] s;
        int          cyc;
    } rsp_t;

    op_t  op_q [NREQ][$];
    fly_t mq[$];
    rsp_t rsp_log[$];
    int   gnt_log[$];

    logic [NREQ-1:0] acc;
    int   load_pct = 100;
    bit   rdy_rand = 0;
    int   rdy_pct  = 70;

    // ---------------- driver tasks ----------------
    task automatic push_op(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [1:0] rm);
        op_t o;
        o.a = a; o.b = b; o.sub = sub; o.rm = rm;
        op_q[i].push_back(o);
    endtask

    task automatic tick();
        op_t o;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && acc[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && op_q[i].size() > 0 && $urandom_range(0, 99) < load_pct) begin
                o = op_q[i].pop_front();
                req_a[32*i +: 32] = o.a;
                req_b[32*i +: 32] = o.b;
                req_sub[i]        = o.sub;
                req_rm[2*i +: 2]  = o.rm;
                req_valid[i]      = 1'b1;
            end
        end
        if (rdy_rand) rsp_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        repeat (2) tick();
        clrn = 1'b1;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (op_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    int              m_ptr   = 0;
    int              en_cnt  = 0;
    int              m_issue = 0;
    int              m_stall = 0;
    int              cyc     = 0;
    int              m_g;
    logic            m_v, m_e;
    logic [NREQ-1:0] m_rdy;
    fly_t            ent;
    rsp_t            rl;

    always @(negedge clk) begin
        cyc++;
        m_v = clrn && mq.size() > 0 && (en_cnt - mq[0].issued >= LAT - 1);
        m_e = !m_v || rsp_ready;
        m_g = -1;
        if (clrn && m_e) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
            end
        end
        m_rdy = '0;
        if (m_g >= 0) m_rdy[m_g] = 1'b1;

        chk("fa_e", fa_e, m_e);
        chk("req_ready", req_ready, m_rdy);
        chk("rsp_valid", rsp_valid, m_v);
        chk("busy", busy, clrn && mq.size() > 0);
        if (m_v) begin
            chk("rsp_id", rsp_id, mq[0].id);
            chk("rsp_s", rsp_s, mq[0].s);
        end
        if (m_g >= 0) begin
            chk("fa_a", fa_a, req_a[32*m_g +: 32]);
            chk("fa_b", fa_b, req_b[32*m_g +: 32]);
            chk("fa_ctl", {fa_sub, fa_rm}, {req_sub[m_g], req_rm[2*m_g +: 2]});
        end else if (clrn && m_e) begin
            chk("fa_bubble", {fa_a, fa_b}, 64'd0);
            chk("fa_bubble_ctl", {fa_sub, fa_rm}, 3'd0);
        end
`ifdef FADD_SHARE_PERF_EN
        if (clrn) begin
            chk("perf_issue", perf_issue, m_issue);
            chk("perf_stall", perf_stall, m_stall);
        end
`endif

        acc = req_ready;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_log.push_back(i);
        if (rsp_valid && rsp_ready) begin
            rl.id = int'(rsp_id); rl.s = rsp_s; rl.cyc = cyc;
            rsp_log.push_back(rl);
        end

        if (!clrn) begin
            mq.delete();
            m_ptr = 0; m_issue = 0; m_stall = 0;
        end else begin
            if (!m_e && (|req_valid)) m_stall++;
            if (m_e) begin
                en_cnt++;
                if (m_v) void'(mq.pop_front());
                if (m_g >= 0) begin
                    ent.id     = m_g;
                    ent.s      = fadd(req_a[32*m_g +: 32], req_b[32*m_g +: 32], req_sub[m_g]);
                    ent.issued = en_cnt;
                    mq.push_back(ent);
                    m_ptr = (m_g + 1) % NREQ;
                    m_issue++;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin : main
        bit done;
        clrn      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        req_rm    = '0;
        rsp_ready = 1'b1;
        acc       = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fa_e", fa_e, 1'b1);
        tick();
        clrn = 1'b1;

        // 1) single add 1.0 + 2.0 from requester 0
        push_op(0, F_ONE, F_TWO, 1'b0, RM_RNE);
        tick();
        @(negedge clk);
        chk("s1_grant", req_ready, 3'b001);
        tick();
        tick();
        @(negedge clk);
        chk("s1_valid", rsp_valid, 1'b1);
        chk("s1_sum", rsp_s, F_THREE);
        chk("s1_id", rsp_id, 0);
        repeat (3) tick();

        // 2) requesters 0 and 1 continuously valid
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push_op(0, r2f(real'($urandom_range(1, 300))), r2f(real'($urandom_range(1, 300))), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            push_op(1, r2f(real'($urandom_range(1, 300))), r2f(real'($urandom_range(1, 300))), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        gnt_log.delete();
        rsp_log.delete();
        repeat (12) tick();
        chk("s2_gnt_count", gnt_log.size() >= 8, 1'b1);
        chk("s2_rsp_count", rsp_log.size() >= 8, 1'b1);
        if (gnt_log.size() >= 8 && rsp_log.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("s2_gnt_order", gnt_log[k], k % 2);
                chk("s2_rsp_id_order", rsp_log[k].id, k % 2);
                if (k > 0) chk("s2_rsp_per_cycle", rsp_log[k].cyc - rsp_log[k-1].cyc, 1);
            end
        end
        repeat (12) tick();

        // 3) pipe full with output stalled for 5 cycles
        do_reset();
        rsp_ready = 1'b0;
        push_op(0, F_ONE, F_TWO, 1'b0, RM_RNE);
        push_op(0, F_THREE, F_ONE, 1'b1, RM_RTZ);
        push_op(1, F_TWO, F_TWO, 1'b0, RM_RNE);
        rsp_log.delete();
        repeat (3) tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("s3_fa_e", fa_e, 1'b0);
            chk("s3_req_ready", req_ready, '0);
            chk("s3_hold_valid", rsp_valid, 1'b1);
            chk("s3_hold_s", rsp_s, F_THREE);
            chk("s3_hold_id", rsp_id, 0);
            tick();
        end
        rsp_ready = 1'b1;
        repeat (6) tick();
        chk("s3_rsp_count", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            chk("s3_r0", {rsp_log[0].id[7:0], rsp_log[0].s}, {8'd0, F_THREE});
            chk("s3_r1", {rsp_log[1].id[7:0], rsp_log[1].s}, {8'd1, F_FOUR});
            chk("s3_r2", {rsp_log[2].id[7:0], rsp_log[2].s}, {8'd0, F_TWO});
        end
`ifdef FADD_SHARE_PERF_EN
        chk("s6_perf_issue", perf_issue, 3);
        chk("s6_perf_stall", perf_stall, 5);
`endif

        // 4) subtract 3.0 - 1.0 from requester 1
        rsp_log.delete();
        push_op(1, F_THREE, F_ONE, 1'b1, RM_RNE);
        repeat (6) tick();
        chk("s4_rsp_count", rsp_log.size(), 1);
        if (rsp_log.size() == 1) begin
            chk("s4_id", rsp_log[0].id, 1);
            chk("s4_diff", rsp_log[0].s, F_TWO);
        end

        // 5) reset with two ops in flight
        do_reset();
        rsp_ready = 1'b0;
        push_op(0, F_ONE, F_ONE, 1'b0, RM_RNE);
        push_op(1, F_TWO, F_ONE, 1'b0, RM_RNE);
        tick();
        tick();
        @(negedge clk);
        chk("s5_busy_before", busy, 1'b1);
        tick();
        clrn = 1'b0;
        rsp_log.delete();
        @(negedge clk);
        chk("s5_rsp_valid_rst", rsp_valid, 1'b0);
        chk("s5_busy_rst", busy, 1'b0);
        tick();
        tick();
        clrn      = 1'b1;
        rsp_ready = 1'b1;
        repeat (8) tick();
        chk("s5_no_stale", rsp_log.size(), 0);
        chk("s5_idle", busy, 1'b0);

        // random traffic on all requesters with random backpressure and one mid-run reset
        rsp_log.delete();
        load_pct = 60;
        rdy_rand = 1;
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 40; k++) begin
                push_op(i, r2f(real'($urandom_range(1, 500))), r2f(real'($urandom_range(1, 500))),
                        1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
        end
        done = 1'b0;
        for (int rc = 0; rc < 4000 && !done; rc++) begin
            tick();
            if (rc == 150) clrn = 1'b0;
            if (rc == 153) clrn = 1'b1;
            if (rc > 160 && all_empty() && req_valid == '0 && !busy) done = 1'b1;
        end
        chk("rand_drain", done, 1'b1);
        chk("rand_responses", rsp_log.size() >= 100, 1'b1);
        rdy_rand  = 0;
        rsp_ready = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
